// File: rtl/cal_pkg.sv
// Shared field widths, month-length table and leap-year rule for the calendar clock.
package cal_pkg;

    localparam int MONTH_W = 4;
    localparam int DAY_W   = 5;
    localparam int HOUR_W  = 5;
    localparam int MIN_W   = 6;
    localparam int SEC_W   = 6;
    localparam int WEEK_W  = 3;

    // Index 0 is January; February holds its common-year length.
    localparam logic [DAY_W-1:0] MONTH_DAYS [12] = '{
        5'd31, 5'd28, 5'd31, 5'd30, 5'd31, 5'd30,
        5'd31, 5'd31, 5'd30, 5'd31, 5'd30, 5'd31
    };

    function automatic logic is_leap(input logic [31:0] y);
        return ((y % 32'd4) == 32'd0) &&
               (((y % 32'd100) != 32'd0) || ((y % 32'd400) == 32'd0));
    endfunction

endpackage

// File: rtl/cal_days_in_month.sv
// Combinational month length lookup: year + month -> 28..31.
module cal_days_in_month
    import cal_pkg::*;
#(
    parameter int YEAR_W = 16
) (
    input  logic [YEAR_W-1:0]  year,
    input  logic [MONTH_W-1:0] month,
    output logic [DAY_W-1:0]   days
);

    // Out-of-range months report 31; callers reject such months separately.
    always_comb begin
        days = 5'd31;
        if (month >= 4'd1 && month <= 4'd12) begin
            days = MONTH_DAYS[month - 4'd1];
            if (month == 4'd2 && is_leap(32'(year))) begin
                days = 5'd29;
            end
        end
    end

endmodule

// File: rtl/calendar_clock_param.sv
// Parametrised seconds/calendar counter with prescaler, validated load and strobes.
// Optional alarm strobe is built when CAL_ALARM_EN is defined.
module calendar_clock_param
    import cal_pkg::*;
#(
    parameter int TICKS_PER_SEC = 1,
    parameter int YEAR_W        = 16,
    parameter int YEAR_MIN      = 2000,
    parameter int YEAR_MAX      = 2099,
    parameter int INIT_YEAR     = 2023,
    parameter int INIT_MONTH    = 5,
    parameter int INIT_DAY      = 9,
    parameter int INIT_HOUR     = 11,
    parameter int INIT_MIN      = 59,
    parameter int INIT_SEC      = 58,
    parameter int INIT_WEEK     = 2
) (
    input  logic                secclk,
    input  logic                rst,
    input  logic                tick_en,
    input  logic                set_valid,
    output logic                set_ready,
    input  logic [YEAR_W-1:0]   set_year,
    input  logic [MONTH_W-1:0]  set_month,
    input  logic [DAY_W-1:0]    set_day,
    input  logic [HOUR_W-1:0]   set_hour,
    input  logic [MIN_W-1:0]    set_min,
    input  logic [SEC_W-1:0]    set_sec,
    input  logic [WEEK_W-1:0]   set_week,
    output logic                set_err,
    input  logic                mode12,
`ifdef CAL_ALARM_EN
    input  logic                alarm_on,
    input  logic [HOUR_W-1:0]   alarm_hour,
    input  logic [MIN_W-1:0]    alarm_min,
    output logic                alarm_stb,
`endif
    output logic [YEAR_W-1:0]   year,
    output logic [MONTH_W-1:0]  month,
    output logic [DAY_W-1:0]    day,
    output logic [HOUR_W-1:0]   hour,
    output logic [MIN_W-1:0]    minute,
    output logic [SEC_W-1:0]    second,
    output logic [WEEK_W-1:0]   week,
    output logic [HOUR_W-1:0]   hour_disp,
    output logic                pm,
    output logic                sec_stb,
    output logic                min_stb,
    output logic                day_stb
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0]     PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [YEAR_W-1:0] YMIN = YEAR_W'(YEAR_MIN);
    localparam logic [YEAR_W-1:0] YMAX = YEAR_W'(YEAR_MAX);

    logic [PW-1:0]      presc;
    logic               sec_evt;
    logic               load_req;
    logic               set_ok;
    logic [DAY_W-1:0]   cur_dim;
    logic [DAY_W-1:0]   set_dim;
    logic               c_min, c_hour, c_day, c_mon, c_year;
    logic [YEAR_W-1:0]  n_year;
    logic [MONTH_W-1:0] n_month;
    logic [DAY_W-1:0]   n_day;
    logic [HOUR_W-1:0]  n_hour;
    logic [MIN_W-1:0]   n_min;
    logic [SEC_W-1:0]   n_sec;
    logic [WEEK_W-1:0]  n_week;

    cal_days_in_month #(.YEAR_W(YEAR_W)) u_dim_cur (
        .year  (year),
        .month (month),
        .days  (cur_dim)
    );

    cal_days_in_month #(.YEAR_W(YEAR_W)) u_dim_set (
        .year  (set_year),
        .month (set_month),
        .days  (set_dim)
    );

    assign set_ready = 1'b1;
    assign load_req  = set_valid && set_ready;
    assign sec_evt   = tick_en && (presc == PRESC_LAST);

    assign set_ok = (set_month >= 4'd1) && (set_month <= 4'd12) &&
                    (set_day >= 5'd1) && (set_day <= set_dim) &&
                    (set_hour <= 5'd23) && (set_min <= 6'd59) && (set_sec <= 6'd59) &&
                    (set_week >= 3'd1) && (set_week <= 3'd7) &&
                    (set_year >= YMIN) && (set_year <= YMAX);

    // Carry chain: every field's next value is formed from the same current snapshot.
    assign c_min  = (second == 6'd59);
    assign c_hour = c_min && (minute == 6'd59);
    assign c_day  = c_hour && (hour == 5'd23);
    assign c_mon  = c_day && (day == cur_dim);
    assign c_year = c_mon && (month == 4'd12);

    always_comb begin
        n_sec   = c_min ? '0 : second + 1'b1;
        n_min   = minute;
        n_hour  = hour;
        n_day   = day;
        n_week  = week;
        n_month = month;
        n_year  = year;
        if (c_min)  n_min  = (minute == 6'd59) ? '0 : minute + 1'b1;
        if (c_hour) n_hour = (hour == 5'd23) ? '0 : hour + 1'b1;
        if (c_day) begin
            n_week = (week == 3'd7) ? 3'd1 : week + 1'b1;
            n_day  = c_mon ? 5'd1 : day + 1'b1;
        end
        if (c_mon)  n_month = c_year ? 4'd1 : month + 1'b1;
        if (c_year) n_year  = (year == YMAX) ? YMIN : year + 1'b1;
    end

    always_ff @(posedge secclk or posedge rst) begin
        if (rst) begin
            presc   <= '0;
            year    <= YEAR_W'(INIT_YEAR);
            month   <= MONTH_W'(INIT_MONTH);
            day     <= DAY_W'(INIT_DAY);
            hour    <= HOUR_W'(INIT_HOUR);
            minute  <= MIN_W'(INIT_MIN);
            second  <= SEC_W'(INIT_SEC);
            week    <= WEEK_W'(INIT_WEEK);
            sec_stb <= 1'b0;
            min_stb <= 1'b0;
            day_stb <= 1'b0;
            set_err <= 1'b0;
        end else begin
            sec_stb <= 1'b0;
            min_stb <= 1'b0;
            day_stb <= 1'b0;
            set_err <= 1'b0;
            // Any load request takes the edge; a coincident tick is dropped.
            if (load_req) begin
                if (set_ok) begin
                    presc  <= '0;
                    year   <= set_year;
                    month  <= set_month;
                    day    <= set_day;
                    hour   <= set_hour;
                    minute <= set_min;
                    second <= set_sec;
                    week   <= set_week;
                end else begin
                    set_err <= 1'b1;
                end
            end else if (tick_en) begin
                presc <= sec_evt ? '0 : presc + 1'b1;
                if (sec_evt) begin
                    year    <= n_year;
                    month   <= n_month;
                    day     <= n_day;
                    hour    <= n_hour;
                    minute  <= n_min;
                    second  <= n_sec;
                    week    <= n_week;
                    sec_stb <= 1'b1;
                    min_stb <= c_min;
                    day_stb <= c_day;
                end
            end
        end
    end

`ifdef CAL_ALARM_EN
    always_ff @(posedge secclk or posedge rst) begin
        if (rst) begin
            alarm_stb <= 1'b0;
        end else begin
            alarm_stb <= !load_req && sec_evt && alarm_on &&
                         (n_hour == alarm_hour) && (n_min == alarm_min) && (n_sec == '0);
        end
    end
`endif

    always_comb begin
        hour_disp = hour;
        if (mode12) begin
            if (hour == 5'd0)       hour_disp = 5'd12;
            else if (hour > 5'd12)  hour_disp = hour - 5'd12;
        end
    end

    assign pm = (hour >= 5'd12);

endmodule

// File: doc/calendar_clock_param.md
Name: calendar_clock_param

Overview:
- Parametrised successor of the seconds/calendar counter: keeps second, minute, hour, day, month, year and weekday, advancing one second per qualified tick.
- Adds:
  - reset to a configurable start date;
  - a validated load (set) handshake;
  - full Gregorian leap-year rule;
  - a prescaler, so the block can also run from a faster clock;
  - a 12/24-hour display mode and rollover strobes.
- Feeds the display/driver logic; the set port is driven by the button/UI controller.

Parameters:
- TICKS_PER_SEC, 1, qualified ticks per second; 1 means every enabled secclk edge is one second.
- YEAR_W, 16, year register width.
- YEAR_MIN, 2000, lowest legal year; wrap target.
- YEAR_MAX, 2099, highest legal year.
- INIT_YEAR, 2023; INIT_MONTH, 5; INIT_DAY, 9; INIT_HOUR, 11; INIT_MIN, 59; INIT_SEC, 58; INIT_WEEK, 2: reset values.

Ports:
- secclk  in  1  clock; one clock domain; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- tick_en  in  1  qualifies secclk edges into the prescaler.
- set_valid  in  1  load request.
- set_ready  out  1  high when a load can be accepted.
- set_year  in  YEAR_W  requested year.
- set_month  in  4  requested month.
- set_day  in  5  requested day.
- set_hour  in  5  requested hour.
- set_min  in  6  requested minute.
- set_sec  in  6  requested second.
- set_week  in  3  requested weekday.
- set_err  out  1  one-cycle pulse: load rejected.
- mode12  in  1  1 selects 12-hour display.
- year  out  YEAR_W  current year.
- month  out  4  current month, 1..12.
- day  out  5  current day of month.
- hour  out  5  current hour, 0..23.
- minute  out  6  current minute.
- second  out  6  current second.
- week  out  3  current weekday, 1..7.
- hour_disp  out  5  hour for display, 24h or 12h form.
- pm  out  1  1 when hour >= 12.
- sec_stb  out  1  one-cycle strobe on a second increment.
- min_stb  out  1  one-cycle strobe on a minute increment.
- day_stb  out  1  one-cycle strobe on a day increment.

Behaviour:
- Reset (async, immediate):
  - time/date fields = INIT_* values; prescaler = 0.
  - All strobes and set_err = 0; set_ready = 1.
- Prescaler: counts enabled edges 0..TICKS_PER_SEC-1. Reaching the terminal count in the same edge = one "second event"; the prescaler returns to 0.
- Second event: all field updates take effect together in that edge (no intermediate out-of-range values are ever visible).
  - second 0..59: increments; 59 -> 0 and carries to minute.
  - minute 0..59: increments; 59 -> 0 and carries to hour.
  - hour 0..23: increments; 23 -> 0 and carries to day and week.
  - week: increments; 7 -> 1.
  - day: increments; last day of month -> 1 and carries to month.
  - month: increments; 12 -> 1 and carries to year.
  - year: increments; YEAR_MAX -> YEAR_MIN.
- Month lengths: 31,28/29,31,30,31,30,31,31,30,31,30,31.
- Leap year = (year%4==0) && ((year%100!=0) || (year%400==0)).
- Strobe registration: sec_stb, min_stb and day_stb are registered and high for exactly the cycle after the update edge.
- Set handshake: a load is accepted on an edge where set_valid && set_ready; set_ready is always 1 in this generation.
- Validation:
  - month 1..12;
  - day 1..days_in_month(set_year, set_month);
  - hour <=23, min <=59, sec <=59;
  - week 1..7;
  - year YEAR_MIN..YEAR_MAX.
- Valid load: all fields are loaded next edge; prescaler clears to 0; strobes are suppressed for that edge.
- Invalid load: no field changes; set_err pulses one cycle.
- Simultaneous load and second event: the load wins and the tick is dropped.
- hour_disp:
  - mode12=0: hour_disp = hour.
  - mode12=1: hour 0 -> 12; hours 1..12 unchanged; 13..23 -> hour-12.
  - pm is independent of mode12. hour_disp and pm are combinational from registered hour.
- tick_en=0: prescaler holds; fields hold.

Optional Feature:
- CAL_ALARM_EN.
- Defined:
  - adds inputs alarm_on (1), alarm_hour (5), alarm_min (6);
  - adds output alarm_stb (1): one-cycle pulse when a second event lands on hour==alarm_hour, minute==alarm_min, second==0, with alarm_on=1;
  - a load to the matching time does not fire the alarm.
- Undefined: these ports do not exist and there is no alarm logic.

Decomposition:
- Package cal_pkg holds:
  - field width localparams: MONTH_W=4, DAY_W=5, HOUR_W=5, MIN_W=6, SEC_W=6, WEEK_W=3;
  - the 12-entry month-length constant array;
  - an is_leap function.
- One sub-module: cal_days_in_month (combinational; year+month -> 28..31). It is instantiated twice: once for the current date, once for load validation.

Test Plan:
- 2024-02-28 23:59:59, week 3, one second event -> 2024-02-29 00:00:00, week 4; day_stb, min_stb and sec_stb each pulse once.
- Load 2100-02-28 23:59:59 with YEAR_MAX=2199, tick -> 2100-03-01; load 2000-02-28 23:59:59, tick -> 2000-02-29.
- 2099-12-31 23:59:59, week 7, tick -> 2000-01-01 00:00:00, week 1 (YEAR_MAX wrap).
- Load year 2023, month 4, day 31 -> set_err pulses, fields unchanged. Load 2023-04-30 10:20:30, week 5, coincident with a tick -> exactly 10:20:30, no strobes.
- TICKS_PER_SEC=4, tick_en toggled every other cycle -> second advances once per 4 enabled edges. mode12=1 with hour 0 / 12 / 13 -> hour_disp 12 / 12 / 1, pm 0 / 1 / 1.
- Assert rst mid-count (prescaler=2, arbitrary date) -> outputs return to INIT_* asynchronously; the first second event follows TICKS_PER_SEC enabled edges after release.
